el2_exu_div_noc_ctrl: RTL and testbench

- Sequences one divide at a time between the EXU divide issue logic and the divider NoC serial sender/receiver pair.
- Latches operands, holds them stable for the sender, and tracks the outstanding request.
- Handles cancel and response timeout, pulses the sender flush between transactions, and returns the quotient/remainder to the EXU.

---
 rtl/el2_exu_div_noc_ctrl_if.sv | 47 ++++
 rtl/el2_exu_div_noc_ctrl.sv | 142 ++++++++++++++
 tb/tb_el2_exu_div_noc_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/el2_exu_div_noc_ctrl_if.sv
// EXU divide / divider NoC handshake bundle.
// slave is the controller side; master is the EXU + NoC environment side.
interface el2_exu_div_noc_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_sign;
  logic        req_rem;
  logic [31:0] req_dividend;
  logic [31:0] req_divisor;
  logic        cancel;
  logic        snd_enable;
  logic        snd_flush;
  logic [2:0]  snd_dp;
  logic        snd_cancel;
  logic [31:0] snd_dividend;
  logic [31:0] snd_divisor;
  logic        snd_ack;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        out_valid;
  logic [31:0] out_data;
  logic        busy;
  logic        timeout_err;
  logic        stray_rsp;

  modport slave (
    input  req_valid, req_sign, req_rem,
    input  req_dividend, req_divisor, cancel,
    input  snd_ack, rsp_valid, rsp_data,
    output req_ready, snd_enable, snd_flush,
    output snd_dp, snd_cancel,
    output snd_dividend, snd_divisor,
    output out_valid, out_data, busy,
    output timeout_err, stray_rsp
  );

  modport master (
    output req_valid, req_sign, req_rem,
    output req_dividend, req_divisor, cancel,
    output snd_ack, rsp_valid, rsp_data,
    input  req_ready, snd_enable, snd_flush,
    input  snd_dp, snd_cancel,
    input  snd_dividend, snd_divisor,
    input  out_valid, out_data, busy,
    input  timeout_err, stray_rsp
  );
endinterface

// File: rtl/el2_exu_div_noc_ctrl.sv
// One-at-a-time divide sequencer between EXU issue and the divider NoC.
// Latches operands for the sender, tracks cancel/timeout, returns result.
module el2_exu_div_noc_ctrl #(
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int CNT_W          = 10
) (
  input logic clk_noc,
  input logic rst_l,
  el2_exu_div_noc_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE, SEND, WAIT_RSP, FLUSH
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [2:0]  dp_q, dp_d;
  logic [31:0] dvd_q, dvd_d;
  logic [31:0] dvs_q, dvs_d;
  logic        killed_q, killed_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic        ready_q, ready_d;
  logic        busy_q, busy_d;
  logic        en_q, en_d;
  logic        flush_q, flush_d;
  logic        ov_q, ov_d;
  logic [31:0] od_q, od_d;
  logic        to_q, to_d;
  logic        stray_q, stray_d;

  always_comb begin
    state_d  = state_q;
    dp_d     = dp_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    killed_d = killed_q;
    cnt_d    = cnt_q;
    od_d     = od_q;
    ov_d     = 1'b0;
    to_d     = 1'b0;
    stray_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        stray_d = bus.rsp_valid;
        // ready_q also masks the first cycle after reset release
        if (ready_q && bus.req_valid && !bus.cancel) begin
          state_d  = SEND;
          dp_d     = {1'b1, bus.req_sign, bus.req_rem};
          dvd_d    = bus.req_dividend;
          dvs_d    = bus.req_divisor;
          killed_d = 1'b0;
        end
      end
      SEND: begin
        stray_d = bus.rsp_valid;
        if (bus.cancel) killed_d = 1'b1;
        if (bus.snd_ack) begin
          state_d = WAIT_RSP;
          cnt_d   = '0;
        end
      end
      WAIT_RSP: begin
        cnt_d = cnt_q + 1'b1;
        if (bus.cancel) killed_d = 1'b1;
        if (bus.rsp_valid) begin
          state_d  = FLUSH;
          dp_d[2]  = 1'b0;
          if (!killed_q && !bus.cancel) begin
            ov_d = 1'b1;
            od_d = bus.rsp_data;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d = FLUSH;
          dp_d[2] = 1'b0;
          to_d    = 1'b1;
        end
      end
      FLUSH: begin
        stray_d = bus.rsp_valid;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
    en_d    = (state_d == SEND);
    flush_d = (state_d == FLUSH);
  end

  always_ff @(posedge clk_noc or negedge rst_l) begin
    if (!rst_l) begin
      state_q  <= IDLE;
      dp_q     <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      killed_q <= 1'b0;
      cnt_q    <= '0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      en_q     <= 1'b0;
      flush_q  <= 1'b0;
      ov_q     <= 1'b0;
      od_q     <= '0;
      to_q     <= 1'b0;
      stray_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      dp_q     <= dp_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      killed_q <= killed_d;
      cnt_q    <= cnt_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      en_q     <= en_d;
      flush_q  <= flush_d;
      ov_q     <= ov_d;
      od_q     <= od_d;
      to_q     <= to_d;
      stray_q  <= stray_d;
    end
  end

  assign bus.req_ready    = ready_q;
  assign bus.busy         = busy_q;
  assign bus.snd_enable   = en_q;
  assign bus.snd_flush    = flush_q;
  assign bus.snd_dp       = dp_q;
  assign bus.snd_dividend = dvd_q;
  assign bus.snd_divisor  = dvs_q;
  // a cancel seen together with snd_ack must still reach the packet
  assign bus.snd_cancel   =
    (state_q == SEND) && (killed_q || bus.cancel);
  assign bus.out_valid    = ov_q;
  assign bus.out_data     = od_q;
  assign bus.timeout_err  = to_q;
  assign bus.stray_rsp    = stray_q;

endmodule

// File: tb/tb_el2_exu_div_noc_ctrl.sv
// Scoreboard bench for el2_exu_div_noc_ctrl.
// Expected results queued when responses are driven, popped on out_valid.
module tb_el2_exu_div_noc_ctrl;

  logic clk_noc = 1'b0;
  logic rst_l   = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  logic [31:0] sb_q [$];

  el2_exu_div_noc_ctrl_if bus ();

  el2_exu_div_noc_ctrl #(
    .TIMEOUT_CYCLES(8),
    .CNT_W(4)
  ) dut (
    .clk_noc(clk_noc),
    .rst_l(rst_l),
    .bus(bus)
  );

  always #5 clk_noc = ~clk_noc;

  function automatic logic [31:0] model(
    input logic s, input logic r,
    input logic [31:0] a, input logic [31:0] b
  );
    logic [31:0] res;
    if (s) begin
      if (r) res = $signed(a) % $signed(b);
      else   res = $signed(a) / $signed(b);
    end else begin
      if (r) res = a % b;
      else   res = a / b;
    end
    return res;
  endfunction

  task automatic step();
    @(posedge clk_noc);
    #1;
  endtask

  task automatic fail(input string n,
                      input logic [31:0] got,
                      input logic [31:0] exp);
    failures++;
    $display("FAIL %s got=%h exp=%h", n, got, exp);
  endtask

  task automatic accept(input logic s, input logic r,
                        input logic [31:0] a,
                        input logic [31:0] b);
    bus.req_valid    = 1'b1;
    bus.req_sign     = s;
    bus.req_rem      = r;
    bus.req_dividend = a;
    bus.req_divisor  = b;
    step();
    bus.req_valid = 1'b0;
  endtask

  task automatic respond(input logic [31:0] d,
                         input logic expect_out);
    if (expect_out) sb_q.push_back(d);
    bus.rsp_valid = 1'b1;
    bus.rsp_data  = d;
    step();
    bus.rsp_valid = 1'b0;
    bus.rsp_data  = 32'h0;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({bus.req_ready, bus.busy, bus.snd_enable,
         bus.snd_flush, bus.out_valid,
         bus.timeout_err, bus.stray_rsp} !== 7'b0)
      fail("reset_ctl", {25'b0, bus.req_ready,
           bus.busy, bus.snd_enable, bus.snd_flush,
           bus.out_valid, bus.timeout_err,
           bus.stray_rsp}, 32'h0);
    checks++;
    if (bus.out_data !== 32'h0 || bus.snd_dp !== 3'b0)
      fail("reset_data", bus.out_data, 32'h0);
    @(negedge clk_noc);
    rst_l = 1'b1;
    step();
    checks++;
    if (bus.req_ready !== 1'b1)
      fail("reset_ready", {31'b0, bus.req_ready}, 32'h1);
  endtask

  task automatic test_basic();
    logic [31:0] exp;
    accept(1'b0, 1'b0, 32'd100, 32'd7);
    checks++;
    if (bus.snd_enable !== 1'b1 || bus.req_ready !== 1'b0
        || bus.busy !== 1'b1)
      fail("basic_send", {29'b0, bus.snd_enable,
           bus.req_ready, bus.busy}, 32'h5);
    checks++;
    if (bus.snd_dp !== 3'b100 || bus.snd_dividend !== 32'd100
        || bus.snd_divisor !== 32'd7)
      fail("basic_latch", bus.snd_dividend, 32'd100);
    repeat (4) step();
    bus.snd_ack = 1'b1;
    step();
    bus.snd_ack = 1'b0;
    checks++;
    if (bus.snd_enable !== 1'b0 || bus.busy !== 1'b1)
      fail("basic_wait", {31'b0, bus.snd_enable}, 32'h0);
    repeat (5) step();
    respond(model(1'b0, 1'b0, 32'd100, 32'd7), 1'b1);
    checks++;
    if (bus.out_valid === 1'b1 && sb_q.size() > 0) begin
      exp = sb_q.pop_front();
      if (bus.out_data !== exp)
        fail("basic_out", bus.out_data, exp);
    end else
      fail("basic_out_valid", {31'b0, bus.out_valid}, 32'h1);
    checks++;
    if (bus.out_data !== 32'd14)
      fail("basic_q14", bus.out_data, 32'd14);
    checks++;
    if (bus.snd_flush !== 1'b1 || bus.snd_dp[2] !== 1'b0)
      fail("basic_flush", {31'b0, bus.snd_flush}, 32'h1);
    step();
    checks++;
    if (bus.req_ready !== 1'b1 || bus.out_valid !== 1'b0
        || bus.snd_flush !== 1'b0 || bus.out_data !== 32'd14)
      fail("basic_idle", {31'b0, bus.req_ready}, 32'h1);
  endtask

  task automatic test_cancel_send();
    accept(1'b0, 1'b0, 32'd50, 32'd5);
    repeat (4) step();
    checks++;
    if (bus.snd_cancel !== 1'b0)
      fail("cxl_pre", {31'b0, bus.snd_cancel}, 32'h0);
    bus.cancel = 1'b1;
    step();
    bus.cancel = 1'b0;
    checks++;
    if (bus.snd_cancel !== 1'b1 || bus.snd_enable !== 1'b1)
      fail("cxl_held", {31'b0, bus.snd_cancel}, 32'h1);
    step();
    checks++;
    if (bus.snd_cancel !== 1'b1)
      fail("cxl_held2", {31'b0, bus.snd_cancel}, 32'h1);
    bus.snd_ack = 1'b1;
    step();
    bus.snd_ack = 1'b0;
    checks++;
    if (bus.snd_cancel !== 1'b0)
      fail("cxl_clear", {31'b0, bus.snd_cancel}, 32'h0);
    step();
    respond(32'hDEAD, 1'b0);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 32'd14)
      fail("cxl_discard", bus.out_data, 32'd14);
    checks++;
    if (bus.snd_flush !== 1'b1)
      fail("cxl_flush", {31'b0, bus.snd_flush}, 32'h1);
    step();
    checks++;
    if (bus.req_ready !== 1'b1)
      fail("cxl_idle", {31'b0, bus.req_ready}, 32'h1);
  endtask

  task automatic test_idle_cancel();
    bus.req_valid    = 1'b1;
    bus.cancel       = 1'b1;
    bus.req_dividend = 32'd77;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (bus.snd_enable !== 1'b0 || bus.req_ready !== 1'b1
          || bus.busy !== 1'b0)
        fail("idle_cancel", {31'b0, bus.snd_enable}, 32'h0);
    end
    bus.req_valid = 1'b0;
    bus.cancel    = 1'b0;
  endtask

  task automatic test_req_in_wait();
    logic [31:0] exp;
    accept(1'b0, 1'b0, 32'd5, 32'd2);
    bus.snd_ack = 1'b1;
    step();
    bus.snd_ack = 1'b0;
    bus.req_valid    = 1'b1;
    bus.req_dividend = 32'd999;
    step();
    checks++;
    if (bus.req_ready !== 1'b0 || bus.busy !== 1'b1
        || bus.snd_enable !== 1'b0
        || bus.snd_dividend !== 32'd5)
      fail("wait_ignore", bus.snd_dividend, 32'd5);
    bus.req_valid = 1'b0;
    respond(model(1'b0, 1'b0, 32'd5, 32'd2), 1'b1);
    checks++;
    if (bus.out_valid === 1'b1 && sb_q.size() > 0) begin
      exp = sb_q.pop_front();
      if (bus.out_data !== exp)
        fail("wait_out", bus.out_data, exp);
    end else
      fail("wait_out_valid", {31'b0, bus.out_valid}, 32'h1);
    step();
  endtask

  task automatic test_timeout(input logic late_rsp);
    logic [31:0] exp;
    accept(1'b0, 1'b1, 32'd9, 32'd4);
    bus.snd_ack = 1'b1;
    step();
    bus.snd_ack = 1'b0;
    for (int i = 1; i < 8; i++) begin
      step();
      checks++;
      if (bus.timeout_err !== 1'b0 || bus.busy !== 1'b1)
        fail("to_early", {31'b0, bus.timeout_err}, 32'h0);
    end
    if (late_rsp) begin
      respond(model(1'b0, 1'b1, 32'd9, 32'd4), 1'b1);
      checks++;
      if (bus.timeout_err !== 1'b0)
        fail("to_rsp_wins", {31'b0, bus.timeout_err}, 32'h0);
      checks++;
      if (bus.out_valid === 1'b1 && sb_q.size() > 0) begin
        exp = sb_q.pop_front();
        if (bus.out_data !== exp)
          fail("to_rsp_out", bus.out_data, exp);
      end else
        fail("to_rsp_valid", {31'b0, bus.out_valid}, 32'h1);
    end else begin
      step();
      checks++;
      if (bus.timeout_err !== 1'b1 || bus.out_valid !== 1'b0)
        fail("to_pulse", {31'b0, bus.timeout_err}, 32'h1);
      checks++;
      if (bus.snd_flush !== 1'b1)
        fail("to_flush", {31'b0, bus.snd_flush}, 32'h1);
    end
    step();
    checks++;
    if (bus.timeout_err !== 1'b0 || bus.req_ready !== 1'b1)
      fail("to_idle", {31'b0, bus.req_ready}, 32'h1);
  endtask

  task automatic test_stray();
    logic [31:0] prev;
    prev = bus.out_data;
    respond(32'h1234, 1'b0);
    checks++;
    if (bus.stray_rsp !== 1'b1 || bus.out_valid !== 1'b0
        || bus.busy !== 1'b0)
      fail("stray_pulse", {31'b0, bus.stray_rsp}, 32'h1);
    step();
    checks++;
    if (bus.stray_rsp !== 1'b0 || bus.out_data !== prev)
      fail("stray_end", bus.out_data, prev);
  endtask

  task automatic test_reset_mid();
    logic [31:0] exp;
    accept(1'b0, 1'b0, 32'd60, 32'd6);
    bus.snd_ack = 1'b1;
    step();
    bus.snd_ack = 1'b0;
    repeat (2) step();
    @(negedge clk_noc);
    rst_l = 1'b0;
    #1;
    checks++;
    if ({bus.req_ready, bus.busy, bus.snd_enable,
         bus.snd_flush, bus.snd_cancel, bus.out_valid,
         bus.timeout_err, bus.stray_rsp} !== 8'b0
        || bus.snd_dp !== 3'b0)
      fail("rst_async_ctl", {29'b0, bus.snd_dp}, 32'h0);
    checks++;
    if (bus.out_data !== 32'h0 || bus.snd_dividend !== 32'h0
        || bus.snd_divisor !== 32'h0)
      fail("rst_async_data", bus.snd_dividend, 32'h0);
    @(negedge clk_noc);
    rst_l = 1'b1;
    step();
    accept(1'b1, 1'b1, 32'hFFFFFFEC, 32'd3);
    checks++;
    if (bus.snd_dp !== 3'b111)
      fail("rst_new_dp", {29'b0, bus.snd_dp}, 32'h7);
    step();
    bus.snd_ack = 1'b1;
    step();
    bus.snd_ack = 1'b0;
    step();
    respond(model(1'b1, 1'b1, 32'hFFFFFFEC, 32'd3), 1'b1);
    checks++;
    if (bus.out_valid === 1'b1 && sb_q.size() > 0) begin
      exp = sb_q.pop_front();
      if (bus.out_data !== exp || exp !== 32'hFFFFFFFE)
        fail("rst_new_out", bus.out_data, 32'hFFFFFFFE);
    end else
      fail("rst_new_valid", {31'b0, bus.out_valid}, 32'h1);
    step();
  endtask

  initial begin
    bus.req_valid    = 1'b0;
    bus.req_sign     = 1'b0;
    bus.req_rem      = 1'b0;
    bus.req_dividend = 32'h0;
    bus.req_divisor  = 32'h0;
    bus.cancel       = 1'b0;
    bus.snd_ack      = 1'b0;
    bus.rsp_valid    = 1'b0;
    bus.rsp_data     = 32'h0;
    test_reset();
    test_basic();
    test_cancel_send();
    test_idle_cancel();
    test_req_in_wait();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_stray();
    test_reset_mid();
    checks++;
    if (sb_q.size() != 0)
      fail("sb_leftover", sb_q.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
